// File: rtl/nes_pad_poller_pkg.sv
// Shared definitions for the NES pad poller: FSM encodings, button bit
// positions, JOYP register location and the pad/JOYP mapping helpers.
package nes_pad_poller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Bit positions inside the active-high button image
  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_SELECT = 6;
  localparam int BTN_START  = 7;

  localparam logic [15:0] JOYP_ADDR     = 16'hFF00;
  localparam int          IF_JOYPAD_BIT = 4;

  // Serial order is A,B,Select,Start,Up,Down,Left,Right (index 0..7)
  function automatic logic [7:0] nes_to_buttons(input logic [7:0] s);
    logic [7:0] b;
    b             = 8'h00;
    b[BTN_A]      = s[0];
    b[BTN_B]      = s[1];
    b[BTN_SELECT] = s[2];
    b[BTN_START]  = s[3];
    b[BTN_UP]     = s[4];
    b[BTN_DOWN]   = s[5];
    b[BTN_LEFT]   = s[6];
    b[BTN_RIGHT]  = s[7];
    return b;
  endfunction

  function automatic logic [3:0] p1_nibble(input logic [7:0] b, input logic [1:0] sel);
    logic [3:0] dirs;
    logic [3:0] btns;
    dirs = sel[0] ? 4'h0 : b[3:0];
    btns = sel[1] ? 4'h0 : b[7:4];
    return ~(dirs | btns);
  endfunction

endpackage

// File: rtl/nes_pad_poller_if.sv
// Pad header pins plus the JOYP/IF-side signals of the pad poller.
interface nes_pad_poller_if;
  logic       enable;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_pulse;
  logic [1:0] p1_sel;
  logic [3:0] p1_out;
  logic [7:0] buttons;
  logic       buttons_valid;
  logic       joypad_irq;

  modport slave (
    input  enable, pad_data, p1_sel,
    output pad_latch, pad_pulse, p1_out, buttons, buttons_valid, joypad_irq
  );

  modport master (
    output enable, pad_data, p1_sel,
    input  pad_latch, pad_pulse, p1_out, buttons, buttons_valid, joypad_irq
  );
endinterface

// File: rtl/nes_pad_poller_sync2.sv
// Two-flop synchronizer for asynchronous header inputs.
module nes_pad_poller_sync2 (
  input  logic clock,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;

  // Double-register the asynchronous input
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/nes_pad_poller.sv
// Periodically latches and shifts in an NES pad, holds the button image and
// presents it as the JOYP low nibble with the joypad interrupt request.
module nes_pad_poller
  import nes_pad_poller_pkg::*;
#(
  parameter int CLK_DIV      = 16,
  parameter int LATCH_CYCLES = 32,
  parameter int POLL_PERIOD  = 65536
) (
  input  logic              clock,
  input  logic              reset_n,
  nes_pad_poller_if.slave   bus
);
  localparam int CW = $clog2((LATCH_CYCLES > CLK_DIV) ? LATCH_CYCLES : CLK_DIV);
  localparam int TW = $clog2(POLL_PERIOD);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO   = '0;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [TW-1:0] TMR_LAST   = TW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMR_ZERO   = '0;
  localparam logic [TW-1:0] TMR_ONE    = TW'(1);

  state_t      r_state;
  state_t      w_next;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_timer;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_buttons;
  logic [3:0]  r_p1;
  logic [3:0]  w_p1;
  logic        r_pending;
  logic        r_latch;
  logic        r_pulse;
  logic        r_valid;
  logic        r_irq;
  logic        w_sync;
  logic        w_start;
  logic        w_latch_end;
  logic        w_half_end;

  nes_pad_poller_sync2 u_sync_data (
    .clock   (clock),
    .reset_n (reset_n),
    .i_d     (bus.pad_data),
    .o_q     (w_sync)
  );

  assign w_latch_end = (r_cnt == LATCH_LAST);
  assign w_half_end  = (r_cnt == HALF_LAST);
  assign w_start     = (r_state == ST_IDLE) && (w_next == ST_LATCH);
  assign w_p1        = p1_nibble(r_buttons, bus.p1_sel);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.enable && ((r_timer == TMR_ZERO) || r_pending)) w_next = ST_LATCH;
        else                                                    w_next = ST_IDLE;
      end
      ST_LATCH: begin
        if (w_latch_end) w_next = ST_SHIFT_HI;
        else             w_next = ST_LATCH;
      end
      ST_SHIFT_HI: begin
        if (w_half_end) w_next = ST_SHIFT_LO;
        else            w_next = ST_SHIFT_HI;
      end
      ST_SHIFT_LO: begin
        if (w_half_end) w_next = (r_idx == 3'd7) ? ST_DONE : ST_SHIFT_HI;
        else            w_next = ST_SHIFT_LO;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Poll timer, phase counter, bit index and shift register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_timer   <= TMR_ZERO;
      r_pending <= 1'b0;
      r_cnt     <= CNT_ZERO;
      r_idx     <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      // Entry counts as tick 0 of the new period, so the next start lands POLL_PERIOD later
      if (w_start)                   r_timer <= TMR_ONE;
      else if (r_timer == TMR_LAST)  r_timer <= TMR_ZERO;
      else                           r_timer <= r_timer + TMR_ONE;

      // A missed wrap, or any disabled cycle, makes the next idle start immediate
      if (w_start)                                  r_pending <= 1'b0;
      else if (!bus.enable || (r_timer == TMR_ZERO)) r_pending <= 1'b1;
      else                                          r_pending <= r_pending;

      if ((r_state == ST_IDLE) || (w_next != r_state)) r_cnt <= CNT_ZERO;
      else                                             r_cnt <= r_cnt + CNT_ONE;

      if (w_start)                                                   r_idx <= 3'd1;
      else if ((r_state == ST_SHIFT_LO) && w_half_end && (r_idx != 3'd7)) r_idx <= r_idx + 3'd1;
      else                                                           r_idx <= r_idx;

      if ((r_state == ST_LATCH) && w_latch_end)        r_shift[0]     <= ~w_sync;
      else if ((r_state == ST_SHIFT_LO) && w_half_end) r_shift[r_idx] <= ~w_sync;
      else                                             r_shift        <= r_shift;
    end
  end

  // Registered pad strobes, button image, JOYP nibble and interrupt
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_latch   <= 1'b0;
      r_pulse   <= 1'b0;
      r_valid   <= 1'b0;
      r_buttons <= 8'h00;
      r_p1      <= 4'hF;
      r_irq     <= 1'b0;
    end else begin
      r_latch <= (w_next == ST_LATCH);
      r_pulse <= (w_next == ST_SHIFT_HI);
      r_valid <= (r_state == ST_DONE);
      if (r_state == ST_DONE) r_buttons <= nes_to_buttons(r_shift);
      else                    r_buttons <= r_buttons;
      r_p1  <= w_p1;
      r_irq <= |(r_p1 & ~w_p1);
    end
  end

  assign bus.pad_latch     = r_latch;
  assign bus.pad_pulse     = r_pulse;
  assign bus.buttons       = r_buttons;
  assign bus.buttons_valid = r_valid;
  assign bus.p1_out        = r_p1;
  assign bus.joypad_irq    = r_irq;

endmodule
